// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared keycode constants, event type and decoder state enum
package mario_pkg;

  localparam logic [7:0] KC_NONE = 8'h00;
  localparam logic [7:0] KC_W    = 8'h1A;
  localparam logic [7:0] KC_A    = 8'h04;
  localparam logic [7:0] KC_S    = 8'h16;
  localparam logic [7:0] KC_D    = 8'h07;

  typedef struct packed {
    logic [7:0] code;
    logic       press;
  } kev_t;

  typedef enum logic [1:0] {
    ST_FILTER,
    ST_EMIT_REL,
    ST_EMIT_PRESS
  } kdec_state_t;

  // Held bitmap order: bit0 W, bit1 A, bit2 S, bit3 D.
  function automatic logic [3:0] held_bits(input logic [7:0] code);
    return {code == KC_D, code == KC_S, code == KC_A, code == KC_W};
  endfunction

endpackage

// File: rtl/keycode_event_decoder_fifo.sv
// rtl/keycode_event_decoder_fifo.sv - show-ahead event FIFO (module kev_fifo)
module kev_fifo
  import mario_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  kev_t                   push_data,
  input  logic                   pop,
  output kev_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  kev_t           mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_pop;
  logic           do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// rtl/keycode_event_decoder.sv - debounces HID keycodes into press/release events and a held bitmap
module keycode_event_decoder
  import mario_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_press,
  output logic [3:0] held,
  output logic       overflow,
  input  logic       clear_ovf
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]              k_q;
  logic [7:0]              cand;
  logic [CNT_W-1:0]        cnt;
  logic [7:0]              acc;
  logic [7:0]              rel_code;
  kdec_state_t             state;
  logic                    accept;
  logic                    push;
  kev_t                    push_data;
  logic                    pop;
  kev_t                    head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k_q  <= KC_NONE;
      cand <= KC_NONE;
      cnt  <= '0;
    end else begin
      k_q <= keycode;
      if (k_q != cand) begin
        cand <= k_q;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Acceptance waits for FILTER so a change arriving mid-emit is picked up afterwards.
  assign accept = (state == ST_FILTER) && (cnt == CNT_MAX) && (k_q == cand) && (cand != acc);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_FILTER;
      acc      <= KC_NONE;
      rel_code <= KC_NONE;
      held     <= 4'b0000;
    end else begin
      case (state)
        ST_FILTER: begin
          if (accept) begin
            acc      <= cand;
            rel_code <= acc;
            held     <= held_bits(cand);
            state    <= (acc != KC_NONE) ? ST_EMIT_REL : ST_EMIT_PRESS;
          end
        end
        ST_EMIT_REL:   state <= (acc != KC_NONE) ? ST_EMIT_PRESS : ST_FILTER;
        ST_EMIT_PRESS: state <= ST_FILTER;
        default:       state <= ST_FILTER;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state)
      ST_EMIT_REL: begin
        push      = 1'b1;
        push_data = '{code: rel_code, press: 1'b0};
      end
      ST_EMIT_PRESS: begin
        push      = 1'b1;
        push_data = '{code: acc, press: 1'b1};
      end
      default: ;
    endcase
  end

  assign pop = ev_ready && !fifo_empty;

  kev_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign ev_valid = (fifo_count != '0);
  assign ev_code  = ev_valid ? head.code : KC_NONE;
  assign ev_press = ev_valid && head.press;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// tb/tb_keycode_event_decoder.sv - directed self-checking bench for keycode_event_decoder
module tb_keycode_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keycode;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_press;
  logic [3:0] held;
  logic       overflow;
  logic       clear_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keycode_event_decoder #(
    .FIFO_DEPTH   (8),
    .STABLE_CYCLES(4)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .keycode  (keycode),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_press (ev_press),
    .held     (held),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; keycode = 8'h00; ev_ready = 1'b0; clear_ovf = 1'b0;
    #2;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    n_checks++; if (ev_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h want 00", ev_code); end
    n_checks++; if (ev_press !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b want 0", ev_press); end
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL reset_held: got %b want 0000", held); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", ev_valid); end
  endtask

  task automatic test_press();
    keycode = 8'h04;
    repeat (5) tick();
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL press_held_early: got %b want 0000", held); end
    tick();
    n_checks++; if (held !== 4'b0010) begin n_fail++; $display("FAIL press_held: got %b want 0010", held); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_valid_early: got %b want 0", ev_valid); end
    tick();
    n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b want 1", ev_valid); end
    n_checks++; if (ev_code !== 8'h04) begin n_fail++; $display("FAIL press_code: got %h want 04", ev_code); end
    n_checks++; if (ev_press !== 1'b1) begin n_fail++; $display("FAIL press_kind: got %b want 1", ev_press); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_drain: got %b want 0", ev_valid); end
    n_checks++; if (ev_code !== 8'h00) begin n_fail++; $display("FAIL press_code_idle: got %h want 00", ev_code); end
  endtask

  task automatic test_release_press();
    keycode = 8'h07;
    repeat (5) tick();
    n_checks++; if (held !== 4'b0010) begin n_fail++; $display("FAIL rp_held_early: got %b want 0010", held); end
    tick();
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL rp_held: got %b want 1000", held); end
    tick();
    n_checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h04 || ev_press !== 1'b0)
      begin n_fail++; $display("FAIL rp_first: got v=%b %h/%b want v=1 04/0", ev_valid, ev_code, ev_press); end
    tick();
    n_checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h04 || ev_press !== 1'b0)
      begin n_fail++; $display("FAIL rp_hold_head: got v=%b %h/%b want v=1 04/0", ev_valid, ev_code, ev_press); end
    ev_ready = 1'b1;
    tick();
    n_checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h07 || ev_press !== 1'b1)
      begin n_fail++; $display("FAIL rp_second: got v=%b %h/%b want v=1 07/1", ev_valid, ev_code, ev_press); end
    tick();
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rp_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_glitch();
    keycode = 8'h00;
    repeat (8) tick();
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL gl_release_held: got %b want 0000", held); end
    n_checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h07 || ev_press !== 1'b0)
      begin n_fail++; $display("FAIL gl_release: got v=%b %h/%b want v=1 07/0", ev_valid, ev_code, ev_press); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    keycode = 8'h1A;
    repeat (3) tick();
    keycode = 8'h00;
    repeat (12) tick();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_event: got %b want 0", ev_valid); end
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL glitch_held: got %b want 0000", held); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    logic [7:0] exp_code [8];
    logic       exp_press [8];
    codes     = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h07};
    exp_code  = '{8'h04, 8'h04, 8'h07, 8'h07, 8'h16, 8'h16, 8'h1A, 8'h1A};
    exp_press = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      keycode = codes[i];
      repeat (8) tick();
      if (i == 3) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ev_valid !== 1'b1 || ev_code !== exp_code[i] || ev_press !== exp_press[i])
        begin n_fail++; $display("FAIL ovf_drain%0d: got v=%b %h/%b want v=1 %h/%b", i, ev_valid, ev_code, ev_press, exp_code[i], exp_press[i]); end
      tick();
    end
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got %b want 0", ev_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] codes [4];
    logic [7:0] exp_code [8];
    logic       exp_press [8];
    codes     = '{8'h04, 8'h16, 8'h1A, 8'h07};
    exp_code  = '{8'h04, 8'h16, 8'h16, 8'h1A, 8'h1A, 8'h07, 8'h07, 8'h04};
    exp_press = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      keycode = codes[i];
      repeat (8) tick();
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
    keycode = 8'h04;
    repeat (6) tick();
    ev_ready = 1'b1;
    tick(); tick();
    ev_ready = 1'b0;
    repeat (2) tick();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ev_valid !== 1'b1 || ev_code !== exp_code[i] || ev_press !== exp_press[i])
        begin n_fail++; $display("FAIL pushpop_drain%0d: got v=%b %h/%b want v=1 %h/%b", i, ev_valid, ev_code, ev_press, exp_code[i], exp_press[i]); end
      tick();
    end
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_reset_mid_emit();
    ev_ready = 1'b0;
    keycode = 8'h16;
    repeat (8) tick();
    keycode = 8'h07;
    repeat (6) tick();
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL rme_held_pre: got %b want 1000", held); end
    rst = 1'b1;
    #1;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rme_valid: got %b want 0", ev_valid); end
    n_checks++; if (ev_code !== 8'h00) begin n_fail++; $display("FAIL rme_code: got %h want 00", ev_code); end
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL rme_held: got %b want 0000", held); end
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rme_early: got %b want 0", ev_valid); end
    repeat (2) tick();
    n_checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h07 || ev_press !== 1'b1)
      begin n_fail++; $display("FAIL rme_press: got v=%b %h/%b want v=1 07/1", ev_valid, ev_code, ev_press); end
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL rme_held_post: got %b want 1000", held); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    repeat (4) tick();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rme_single: got %b want 0", ev_valid); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release_press();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keycode_event_decoder.md
# keycode_event_decoder

Converts the raw 8-bit USB HID keycode written by the Nios keyboard driver into filtered press/release events and a held-key bitmap for the game logic. Sits between the SoC `keycode` export and the sprite/motion blocks. Filters glitches and transient values, emits one event per edge of the accepted code, and buffers events in a small FIFO. The FIFO is drained by the consumer with a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `STABLE_CYCLES`, 4: consecutive identical samples needed before a code is accepted; ≥2.

Ports:
- `Clk` in 1: system clock; all logic on rising edge.
- `Reset` in 1: reset is asynchronous and active-high; one clock domain only.
- `keycode` in 8: raw code from SoC; 0x00 = no key.
- `ev_ready` in 1: consumer accepts head event this cycle.
- `ev_valid` out 1: FIFO non-empty.
- `ev_code` out 8: head event keycode; 0x00 when `ev_valid`=0.
- `ev_press` out 1: 1 = press, 0 = release; 0 when `ev_valid`=0.
- `held` out 4: bit0 W (0x1A), bit1 A (0x04), bit2 S (0x16), bit3 D (0x07); 1 while the accepted code equals that key.
- `overflow` out 1: sticky; an event was dropped.
- `clear_ovf` in 1: synchronous clear of `overflow`.

## Operation
- Input register `k_q` samples `keycode` every cycle.
- Filter: `cand` (8b), `cnt` (width clog2(STABLE_CYCLES)).
  - `k_q != cand`: `cand<=k_q`, `cnt<=0`.
  - Otherwise `cnt` increments, saturating at STABLE_CYCLES-1.
- Accept condition: FSM in FILTER, `cnt==STABLE_CYCLES-1`, `k_q==cand`, and `cand != acc`.
- On accept:
  - `acc<=cand` and `held` updates.
  - Next state is EMIT_REL if old `acc` ≠ 0x00; else EMIT_PRESS.
- FSM states:
  - FILTER: idle and filtering.
  - EMIT_REL: push {old code, release}. Next state is EMIT_PRESS if new `acc` ≠ 0x00, else FILTER.
  - EMIT_PRESS: push {`acc`, press}, then FILTER.
- The filter keeps sampling during EMIT states; acceptance is deferred until the FSM returns to FILTER.
- Old code is held in register `rel_code` for EMIT_REL.
- FIFO behaviour:
  - Show-ahead; pop on `ev_valid && ev_ready`.
  - Occupancy counter is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- Full FIFO with a push and no pop: event dropped, `overflow<=1`. The FSM still advances.
- Full FIFO with a push and a pop in the same cycle: both happen, no overflow.
- Empty FIFO with a push: event visible on `ev_valid` the cycle after the push edge. There is no bypass.
- `ev_ready` while empty is ignored.
- `clear_ovf` coinciding with a drop: set wins.
- A single code change yields exactly one release, one press, or both (release first). Codes present fewer than STABLE_CYCLES samples produce nothing.

## Timing
- Reset values:
  - `k_q`, `cand`, `acc`, `rel_code` = 0x00; `cnt`=0; FSM = FILTER.
  - FIFO empty; `ev_valid`=0; `ev_code`=0x00; `ev_press`=0; `held`=0; `overflow`=0.
- Latency, with `keycode` changed before edge E0 and held stable (S = STABLE_CYCLES):
  - `k_q` updates at E0; `cand` updates at E1.
  - Accept at E(S+1); `held` reflects the new code after that edge.
  - First push at E(S+2); `ev_valid` is high after E(S+2) if the FIFO was empty.
  - Second push (press after release) at E(S+3).
- Reset asserted mid-emit: pending events are lost and the FIFO is cleared.
- After reset deassert with a nonzero `keycode`, the code is filtered again and a single press is emitted. No release is emitted.

## Structure
- Shared package `mario_pkg`:
  - keycode constants `KC_NONE`, `KC_W`, `KC_A`, `KC_S`, `KC_D`;
  - `kev_t` packed struct {code[7:0], press};
  - FSM enum `kdec_state_t`.
- Sub-module `kev_fifo`: parameterised show-ahead FIFO of `kev_t`, with push/pop/full/empty/count ports and the same asynchronous reset.

## Test plan
- Reset, then `keycode` 0x00→0x04 at E0 (S=4): `held`=4'b0010 after E5; `ev_valid` high after E6 with {0x04, press}; `ev_ready`=1 empties the FIFO next edge.
- Change 0x04→0x07 with the FIFO empty and `ev_ready`=0: {0x04, release} then {0x07, press} in order; `held` goes 0010→1000.
- Pulse `keycode`=0x1A for 3 cycles, then back to 0x00: no events, `held` unchanged.
- With `ev_ready`=0, generate 5 code changes (9 events, depth 8): the 9th is dropped and `overflow`=1. With `ev_ready` held at 1, pushes land on the full FIFO in the same cycle as pops and nothing is dropped. `clear_ovf` clears `overflow`.
- Assert `Reset` while in EMIT_REL: outputs return to reset values immediately; with `keycode`=0x07 held, a single {0x07, press} arrives S+2 edges after deassert.
